alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 193 +++++++++++++++++++
 tb/tb_alu_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with valid/ready handshake and iterative MUL/DIV
// Optional iterative restoring divider for opcode 3: define ALU_DIV_EN
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           r_state;
    logic             r_in_ready, r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_carry, r_zero, r_neg, r_ovf, r_err;
    logic [WIDTH-1:0] r_acc, r_q, r_b;
    logic [CNT_W-1:0] r_cnt;
`ifdef ALU_DIV_EN
    logic             r_div;
    logic [WIDTH:0]   w_shift, w_trial;
`endif

    logic [WIDTH:0]   w_sum, w_dif, w_madd;
    logic [WIDTH-1:0] w_res, w_nacc, w_nq;
    logic             w_c, w_v, w_e, w_iter;

    assign w_sum = {1'b0, a} + {1'b0, b};
    assign w_dif = {1'b0, a} - {1'b0, b};

    always_comb begin
        w_res  = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        w_e    = 1'b0;
        w_iter = 1'b0;
        case (alu_sel)
            4'd0: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'd1: begin
                w_res = w_dif[WIDTH-1:0];
                w_c   = w_dif[WIDTH];
                w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
            end
            4'd2: w_iter = 1'b1;
            4'd3: begin
`ifdef ALU_DIV_EN
                if (b == '0) begin
                    w_res = '1;
                    w_e   = 1'b1;
                end else begin
                    w_iter = 1'b1;
                end
`else
                w_e = 1'b1;
`endif
            end
            4'd4: begin w_res = {a[WIDTH-2:0], 1'b0};      w_c = a[WIDTH-1]; end
            4'd5: begin w_res = {1'b0, a[WIDTH-1:1]};      w_c = a[0];       end
            4'd6: begin w_res = {a[WIDTH-2:0], a[WIDTH-1]}; w_c = a[WIDTH-1]; end
            4'd7: begin w_res = {a[0], a[WIDTH-1:1]};      w_c = a[0];       end
            4'd8:  w_res = a & b;
            4'd9:  w_res = a | b;
            4'd10: w_res = a ^ b;
            4'd11: w_res = ~(a | b);
            4'd12: w_res = ~(a & b);
            4'd13: w_res = ~(a ^ b);
            4'd14: w_res = {{(WIDTH-1){1'b0}}, (a > b)};
            default: w_res = {{(WIDTH-1){1'b0}}, (a == b)};
        endcase
    end

    // One iteration step: {acc,q} shifts right for multiply, left for divide
`ifdef ALU_DIV_EN
    assign w_shift = {r_acc, r_q[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_b};
`endif

    always_comb begin
        w_madd = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
        w_nacc = w_madd[WIDTH:1];
        w_nq   = {w_madd[0], r_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        if (r_div) begin
            if (!w_trial[WIDTH]) begin
                w_nacc = w_trial[WIDTH-1:0];
                w_nq   = {r_q[WIDTH-2:0], 1'b1};
            end else begin
                w_nacc = w_shift[WIDTH-1:0];
                w_nq   = {r_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
            r_acc       <= '0;
            r_q         <= '0;
            r_b         <= '0;
            r_cnt       <= '0;
`ifdef ALU_DIV_EN
            r_div       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        if (w_iter) begin
                            r_state <= EXEC;
                            r_acc   <= '0;
                            r_q     <= a;
                            r_b     <= b;
                            r_cnt   <= CNT_W'(WIDTH);
`ifdef ALU_DIV_EN
                            r_div   <= alu_sel[0];
`endif
                        end else begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_res;
                            r_carry     <= w_c;
                            r_zero      <= (w_res == '0);
                            r_neg       <= w_res[WIDTH-1];
                            r_ovf       <= w_v;
                            r_err       <= w_e;
                        end
                    end
                end
                EXEC: begin
                    r_acc <= w_nacc;
                    r_q   <= w_nq;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_nq;
`ifdef ALU_DIV_EN
                        r_carry     <= !r_div && (w_nacc != '0);
`else
                        r_carry     <= (w_nacc != '0);
`endif
                        r_zero      <= (w_nq == '0);
                        r_neg       <= w_nq[WIDTH-1];
                        r_ovf       <= 1'b0;
                        r_err       <= 1'b0;
                    end
                end
                default: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign carry     = r_carry;
    assign zero      = r_zero;
    assign neg       = r_neg;
    assign ovf       = r_ovf;
    assign err       = r_err;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq against a behavioural model
module tb_alu_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   alu_sel = '0;
    logic         in_ready, out_valid, carry, zero, neg, ovf, err;
    logic [W-1:0] result;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rdy_mode = 0;
    bit mon_en = 0;
    bit exp_zero = 1;

    typedef struct {
        logic [W-1:0] res;
        logic c, z, n, v, e;
        int lat;
        int rdy;
    } exp_t;

    exp_t q[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_sel(alu_sel), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .zero(zero), .neg(neg), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input int ai, input int bi, input int sel);
        exp_t e;
        int r, sa, sb, s;
        e.c = 0; e.v = 0; e.e = 0; e.lat = 0; e.rdy = 0;
        r = 0;
        sa = (ai >= 128) ? ai - 256 : ai;
        sb = (bi >= 128) ? bi - 256 : bi;
        case (sel)
            0: begin r = ai + bi; e.c = (r > 255); s = sa + sb; e.v = (s > 127) || (s < -128); end
            1: begin r = ai - bi; e.c = (ai < bi); s = sa - sb; e.v = (s > 127) || (s < -128); end
            2: begin r = ai * bi; e.c = (r > 255); e.lat = W; end
            3: begin
`ifdef ALU_DIV_EN
                if (bi == 0) begin r = 255; e.e = 1; end
                else begin r = ai / bi; e.lat = W; end
`else
                r = 0; e.e = 1;
`endif
            end
            4: begin r = ai * 2; e.c = (ai >= 128); end
            5: begin r = ai / 2; e.c = (ai % 2 == 1); end
            6: begin r = ai * 2 + ai / 128; e.c = (ai >= 128); end
            7: begin r = ai / 2 + (ai % 2) * 128; e.c = (ai % 2 == 1); end
            8: r = ai & bi;
            9: r = ai | bi;
            10: r = ai ^ bi;
            11: r = ~(ai | bi);
            12: r = ~(ai & bi);
            13: r = ~(ai ^ bi);
            14: r = (ai > bi) ? 1 : 0;
            default: r = (ai == bi) ? 1 : 0;
        endcase
        r = r & 255;
        e.res = r[W-1:0];
        e.z = (r == 0);
        e.n = (r >= 128);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        bit ev, can_acc;
        if (mon_en) begin
            ev = (q.size() > 0) && (cyc >= q[0].rdy);
            can_acc = (q.size() == 0);
            chk("out_valid", out_valid, ev);
            chk("in_ready", in_ready, can_acc);
            if (ev) begin
                chk("result", result, q[0].res);
                chk("carry", carry, q[0].c);
                chk("zero", zero, q[0].z);
                chk("neg", neg, q[0].n);
                chk("ovf", ovf, q[0].v);
                chk("err", err, q[0].e);
            end
            if (exp_zero) begin
                chk("rst_result", result, 0);
                chk("rst_flags", {carry, zero, neg, ovf, err}, 0);
                exp_zero = 0;
            end
            if (rst) begin
                q.delete();
                exp_zero = 1;
            end else begin
                if (ev && out_ready) void'(q.pop_front());
                if (in_valid && can_acc) begin
                    e = model(int'(a), int'(b), int'(alu_sel));
                    e.rdy = cyc + 1 + e.lat;
                    q.push_back(e);
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = (rdy_mode == 1) ? 1'b0 : (rdy_mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [3:0] ts);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        @(posedge clk);
        #1;
        a = ta; b = tb; alu_sel = ts; in_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); alu_sel = 4'($urandom);
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic expect_out(input string name, input logic [W-1:0] r, input logic [4:0] czvne, input int nwait);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_wait"}, n, nwait);
        chk({name, "_res"}, result, r);
        chk({name, "_flags"}, {carry, zero, neg, ovf, err}, czvne);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 8'hFF;
            2: return 8'h80;
            3: return 8'h7F;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        exp_t m;
        int n;
        m = model(8'hF6, 8'h0A, 0); chk("model_add_wrap", {m.res, m.c, m.z, m.v}, {8'h00, 3'b110});
        m = model(8'h7F, 8'h01, 0); chk("model_add_ovf", {m.res, m.v, m.n}, {8'h80, 2'b11});
        m = model(8'h0F, 8'h11, 2); chk("model_mul", {m.res, m.c, 8'(m.lat)}, {8'hFF, 1'b0, 8'd8});
        m = model(8'h81, 8'h00, 6); chk("model_rol", {m.res, m.c}, {8'h03, 1'b1});
        m = model(8'h05, 8'h09, 1); chk("model_sub_borrow", {m.res, m.c, m.v}, {8'hFC, 2'b10});
        m = model(8'h80, 8'h01, 1); chk("model_sub_ovf", {m.res, m.v}, {8'h7F, 1'b1});

        repeat (3) @(posedge clk);
        #1 mon_en = 1;
        @(posedge clk);
        #1 rst = 1'b0;

        // carry,zero,neg,ovf,err order in the flag literals
        do_op(8'h0A, 8'h02, 4'd0); expect_out("add", 8'h0C, 5'b00000, 0);
        do_op(8'hF6, 8'h0A, 4'd0); expect_out("add_wrap", 8'h00, 5'b11000, 0);
        do_op(8'h7F, 8'h01, 4'd0); expect_out("add_ovf", 8'h80, 5'b00110, 0);
        do_op(8'h0F, 8'h11, 4'd2); expect_out("mul", 8'hFF, 5'b00100, 8);
        do_op(8'h20, 8'h10, 4'd2); expect_out("mul_hi", 8'h00, 5'b11000, 8);
`ifdef ALU_DIV_EN
        do_op(8'h64, 8'h07, 4'd3); expect_out("div", 8'h0E, 5'b00000, 8);
        do_op(8'h64, 8'h00, 4'd3); expect_out("div0", 8'hFF, 5'b00101, 0);
`else
        do_op(8'h64, 8'h07, 4'd3); expect_out("div_off", 8'h00, 5'b01001, 0);
`endif

        rdy_mode = 1;
        do_op(8'h81, 8'h00, 4'd6); expect_out("rol", 8'h03, 5'b10000, 0);
        repeat (5) begin
            @(negedge clk);
            chk("hold_res", {result, carry, in_ready, out_valid}, {8'h03, 3'b101});
        end
        rdy_mode = 2;
        @(posedge clk);
        #1;
        @(negedge clk);
        @(negedge clk);
        chk("release", {in_ready, out_valid}, 2'b10);

        rdy_mode = 1;
        do_op(8'h03, 8'h05, 4'd2);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort", {in_ready, out_valid, result}, {2'b10, 8'h00});
        rdy_mode = 0;
        do_op(8'h11, 8'h22, 4'd0); expect_out("after_rst", 8'h33, 5'b00000, 0);

        for (int i = 0; i < 400; i++) begin
            do_op(pick(), pick(), 4'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        rdy_mode = 2;
        n = 0;
        while (q.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
